// File: rtl/archer_mmio_console_pkg.sv
// Shared constants for the Archer MMIO console: bus widths, register
// offsets, STATUS bit positions and a byte-enable merge helper.
package archer_mmio_console_pkg;

  localparam int XLEN    = 32;
  localparam int ADDRLEN = 32;

  // Register offsets, selected by dmem_addr[3:2].
  typedef enum logic [1:0] {
    MMIO_TXDATA = 2'd0,
    MMIO_STATUS = 2'd1,
    MMIO_CYCLE  = 2'd2,
    MMIO_HALT   = 2'd3
  } mmio_reg_e;

  // STATUS register layout.
  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_CNT_LSB   = 8;

  // Replace only the bytes of old_v whose enable bit is set.
  function automatic logic [XLEN-1:0] merge_bytes(
    input logic [XLEN-1:0] old_v,
    input logic [XLEN-1:0] new_v,
    input logic [3:0]      ben
  );
    logic [XLEN-1:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (ben[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/archer_mmio_console_fifo.sv
// Synchronous byte FIFO with push, pop and flush. Flush dominates both
// push and pop; a push into a full FIFO is accepted only alongside a pop.
module archer_mmio_console_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];

  assign w_pop_ok  = i_pop && !o_empty && !i_flush;
  assign w_push_ok = i_push && !i_flush && (!o_full || w_pop_ok);

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Byte storage.
  // NOTE: the array has no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/archer_mmio_console.sv
// Archer MMIO console: 16-byte register window with TX byte FIFO,
// free-running cycle counter and sticky halt/tohost register.
module archer_mmio_console
  import archer_mmio_console_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_FF00,
  parameter int          DEPTH     = 8,
  parameter int          CNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDRLEN-1:0] i_dmem_addr,
  input  logic [XLEN-1:0]    i_dmem_datain,
  output logic [XLEN-1:0]    o_dmem_dataout,
  input  logic               i_dmem_wen,
  input  logic [3:0]         i_dmem_ben,
  output logic               o_mmio_sel,
  output logic               o_tx_valid,
  output logic [7:0]         o_tx_data,
  input  logic               i_tx_ready,
  output logic               o_halt,
  output logic [XLEN-1:0]    o_halt_code
);

  mmio_reg_e       w_off;
  logic            w_wr;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;
  logic            w_ovf_clr;
  logic            w_full;
  logic            w_empty;
  logic [CNT_W-1:0] w_count;
  logic [XLEN-1:0] w_status;
  logic            w_unused_addr;
  logic            r_ovf;
  logic            r_halt;
  logic [XLEN-1:0] r_halt_code;
  logic [XLEN-1:0] r_cycle;

  assign o_mmio_sel    = (i_dmem_addr[ADDRLEN-1:4] == BASE_ADDR[ADDRLEN-1:4]);
  assign w_off         = mmio_reg_e'(i_dmem_addr[3:2]);
  assign w_unused_addr = ^i_dmem_addr[1:0];

  assign w_wr      = o_mmio_sel && i_dmem_wen;
  assign w_push    = w_wr && (w_off == MMIO_TXDATA) && i_dmem_ben[0];
  assign w_flush   = w_wr && (w_off == MMIO_STATUS) && i_dmem_ben[0] && i_dmem_datain[0];
  assign w_ovf_clr = w_wr && (w_off == MMIO_STATUS) && i_dmem_ben[0] && i_dmem_datain[2];
  assign w_pop     = o_tx_valid && i_tx_ready;

  archer_mmio_console_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (i_dmem_datain[7:0]),
    .o_data  (o_tx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign o_tx_valid  = !w_empty;
  assign o_halt      = r_halt;
  assign o_halt_code = r_halt_code;

  // STATUS word assembled from live FIFO flags and the sticky overflow bit.
  always_comb begin
    w_status                        = '0;
    w_status[STATUS_CNT_LSB +: 8]   = 8'(w_count);
    w_status[STATUS_OVF_BIT]        = r_ovf;
    w_status[STATUS_EMPTY_BIT]      = w_empty;
    w_status[STATUS_FULL_BIT]       = w_full;
  end

  // Combinational load path; zero when the window is not addressed.
  // NOTE: assigning a default first keeps this block free of latches.
  always_comb begin
    o_dmem_dataout = '0;
    if (o_mmio_sel) begin
      case (w_off)
        MMIO_STATUS: o_dmem_dataout = w_status;
        MMIO_CYCLE:  o_dmem_dataout = r_cycle;
        MMIO_HALT:   o_dmem_dataout = r_halt_code;
        default:     o_dmem_dataout = '0;
      endcase
    end
  end

  // Sticky overflow: a dropped push sets it, a STATUS write with bit 2 clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_full && !w_pop && !w_flush) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // Free-running cycle counter; a store loads it instead of incrementing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle <= '0;
    end else if (w_wr && (w_off == MMIO_CYCLE)) begin
      r_cycle <= merge_bytes(r_cycle, i_dmem_datain, i_dmem_ben);
    end else begin
      r_cycle <= r_cycle + 1'b1;
    end
  end

  // Halt register: any store sets halt and loads the enabled code bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halt      <= 1'b0;
      r_halt_code <= '0;
    end else if (w_wr && (w_off == MMIO_HALT)) begin
      r_halt      <= 1'b1;
      r_halt_code <= merge_bytes(r_halt_code, i_dmem_datain, i_dmem_ben);
    end
  end

endmodule

// File: tb/tb_archer_mmio_console.sv
// Directed bench for archer_mmio_console with a byte scoreboard on the
// TX stream and immediate-assertion checks at every comparison point.
module tb_archer_mmio_console;

  localparam logic [31:0] BASE  = 32'h0000_FF00;
  localparam int          DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_datain;
  logic [31:0] dmem_dataout;
  logic        dmem_wen;
  logic [3:0]  dmem_ben;
  logic        mmio_sel;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halt;
  logic [31:0] halt_code;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic        exp_ovf;
  logic [31:0] rd;

  archer_mmio_console #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH),
    .CNT_W     (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_dmem_addr    (dmem_addr),
    .i_dmem_datain  (dmem_datain),
    .o_dmem_dataout (dmem_dataout),
    .i_dmem_wen     (dmem_wen),
    .i_dmem_ben     (dmem_ben),
    .o_mmio_sel     (mmio_sel),
    .o_tx_valid     (tx_valid),
    .o_tx_data      (tx_data),
    .i_tx_ready     (tx_ready),
    .o_halt         (halt),
    .o_halt_code    (halt_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_exp();
    logic [31:0] s;
    s        = '0;
    s[15:8]  = 8'(exp_q.size());
    s[2]     = exp_ovf;
    s[1]     = (exp_q.size() == 0);
    s[0]     = (exp_q.size() == DEPTH);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational read; costs 1 ns, kept to at most two per clock.
  task automatic read(input logic [31:0] addr, output logic [31:0] data);
    dmem_addr = addr;
    dmem_wen  = 1'b0;
    #1;
    data = dmem_dataout;
  endtask

  // One clock with an optional store; updates the scoreboard model and
  // compares any byte the DUT hands over on this edge.
  task automatic step(input logic wen, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] ben);
    logic       sel;
    logic       wr;
    logic [1:0] off;
    logic [7:0] front;
    sel = (addr[31:4] == BASE[31:4]);
    wr  = wen && sel;
    off = addr[3:2];
    dmem_addr   = addr;
    dmem_datain = data;
    dmem_ben    = ben;
    dmem_wen    = wen;
    check("tx_valid", {31'b0, tx_valid}, {31'b0, exp_q.size() != 0});
    if (wr && off == 2'd1 && ben[0] && data[0]) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && tx_ready) begin
        front = exp_q.pop_front();
        check("tx_data", {24'b0, tx_data}, {24'b0, front});
      end
      if (wr && off == 2'd0 && ben[0]) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(data[7:0]);
        else                      exp_ovf = 1'b1;
      end
    end
    if (wr && off == 2'd1 && ben[0] && data[2]) exp_ovf = 1'b0;
    tick();
    dmem_wen = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    rst_n       = 1'b0;
    dmem_addr   = '0;
    dmem_datain = '0;
    dmem_wen    = 1'b0;
    dmem_ben    = '0;
    tx_ready    = 1'b0;
    exp_ovf     = 1'b0;

    // Reset then idle.
    #6 rst_n = 1'b1;
    check("rst_halt", {31'b0, halt}, 32'd0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    read(BASE + 32'h4, rd);
    check("rst_status", rd, 32'h0000_0002);
    read(BASE + 32'h8, rd);
    check("rst_cycle", rd, 32'd0);
    tick();
    read(BASE + 32'h8, rd);
    check("cycle_plus1", rd, 32'd1);
    tick();
    read(BASE + 32'h8, rd);
    check("cycle_plus2", rd, 32'd2);
    check("sel_in", {31'b0, mmio_sel}, 32'd1);
    read(BASE + 32'h10, rd);
    check("sel_out", {31'b0, mmio_sel}, 32'd0);
    check("read_out_zero", rd, 32'd0);

    // Single byte.
    step(1'b1, BASE, 32'h0000_0041, 4'b0001);
    check("single_valid", {31'b0, tx_valid}, 32'd1);
    check("single_data", {24'b0, tx_data}, 32'h41);
    read(BASE + 32'h4, rd);
    check("single_status", rd, 32'h0000_0100);
    read(BASE, rd);
    check("txdata_reads0", rd, 32'd0);
    tx_ready = 1'b1;
    idle();
    tx_ready = 1'b0;
    read(BASE + 32'h4, rd);
    check("single_drained", rd, 32'h0000_0002);

    // Ignored stores: ben[0]=0 and outside the window.
    step(1'b1, BASE, 32'h0000_0055, 4'b1110);
    step(1'b1, BASE + 32'h10, 32'h0000_0066, 4'b0001);
    read(BASE + 32'h4, rd);
    check("ignored_push", rd, status_exp());

    // Overflow: nine pushes into eight slots.
    for (int i = 1; i <= 9; i++) step(1'b1, BASE, i, 4'b0001);
    read(BASE + 32'h4, rd);
    check("ovf_status", rd, 32'h0000_0805);
    check("ovf_model", rd, status_exp());
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) idle();
    tx_ready = 1'b0;
    read(BASE + 32'h4, rd);
    check("ovf_drained", rd, 32'h0000_0006);
    step(1'b1, BASE + 32'h4, 32'h0000_0004, 4'b0001);
    read(BASE + 32'h4, rd);
    check("ovf_cleared", rd, 32'h0000_0002);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 8; i++) step(1'b1, BASE, 32'h10 + i, 4'b0001);
    tx_ready = 1'b1;
    step(1'b1, BASE, 32'h0000_00AA, 4'b0001);
    tx_ready = 1'b0;
    read(BASE + 32'h4, rd);
    check("full_pushpop", rd, 32'h0000_0801);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) idle();
    tx_ready = 1'b0;
    read(BASE + 32'h4, rd);
    check("full_drained", rd, 32'h0000_0002);

    // Flush with a coincident pop, then confirm pointers restart cleanly.
    step(1'b1, BASE, 32'h21, 4'b0001);
    step(1'b1, BASE, 32'h22, 4'b0001);
    tx_ready = 1'b1;
    step(1'b1, BASE + 32'h4, 32'h0000_0001, 4'b0001);
    tx_ready = 1'b0;
    read(BASE + 32'h4, rd);
    check("flush_status", rd, 32'h0000_0002);
    step(1'b1, BASE, 32'h33, 4'b0001);
    check("after_flush_data", {24'b0, tx_data}, 32'h33);
    tx_ready = 1'b1;
    idle();
    idle();
    tx_ready = 1'b0;

    // Halt and cycle counter.
    step(1'b1, BASE + 32'hC, 32'h0000_0001, 4'b1111);
    check("halt_set", {31'b0, halt}, 32'd1);
    check("halt_code", halt_code, 32'h0000_0001);
    step(1'b1, BASE + 32'hC, 32'hABCD_1234, 4'b0100);
    read(BASE + 32'hC, rd);
    check("halt_code_ben", rd, 32'h00CD_0001);
    step(1'b1, BASE + 32'h8, 32'hFFFF_FFFE, 4'b1111);
    read(BASE + 32'h8, rd);
    check("cycle_load", rd, 32'hFFFF_FFFE);
    tick();
    read(BASE + 32'h8, rd);
    check("cycle_max", rd, 32'hFFFF_FFFF);
    tick();
    read(BASE + 32'h8, rd);
    check("cycle_wrap", rd, 32'h0000_0000);
    check("halt_sticky", {31'b0, halt}, 32'd1);

    // Asynchronous reset between edges discards everything.
    for (int i = 0; i < 3; i++) step(1'b1, BASE, 32'h70 + i, 4'b0001);
    step(1'b1, BASE + 32'hC, 32'h0000_0007, 4'b1111);
    check("pre_rst_valid", {31'b0, tx_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    check("arst_valid", {31'b0, tx_valid}, 32'd0);
    check("arst_halt", {31'b0, halt}, 32'd0);
    check("arst_code", halt_code, 32'd0);
    read(BASE + 32'h4, rd);
    check("arst_status", rd, 32'h0000_0002);
    rst_n = 1'b1;
    tick();
    idle();
    read(BASE + 32'h4, rd);
    check("post_rst_status", rd, status_exp());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
